// File: rtl/keypad_code_entry.sv
// Keypad front end: sync/debounce four buttons and assemble a code for the lock.
// Build option ENTRY_TIMEOUT_EN adds an idle timeout that discards partial entries.
module keypad_code_entry #(
  parameter int CODE_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              btn_zero,
  input  logic                              btn_one,
  input  logic                              btn_enter,
  input  logic                              btn_clear,
  output logic [CODE_WIDTH-1:0]             password,
  output logic                              open,
  output logic [$clog2(CODE_WIDTH+1)-1:0]   digit_count,
  output logic                              entry_err,
  output logic                              entry_timeout
);

  localparam int CNT_W = $clog2(CODE_WIDTH+1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CODE_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    FULL,
    SUBMIT
  } state_t;

  state_t state, state_n;

  logic [3:0] raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb;
  logic [3:0] deb_q;
  logic [3:0] ev;
  logic [DB_W-1:0] db_cnt [4];

  logic [CODE_WIDTH-1:0] code, code_n;
  logic [CODE_WIDTH-1:0] pw_n;
  logic [CNT_W-1:0]      count_n;
  logic                  open_n;
  logic                  err_n;
  logic                  digit_ev;
  logic                  tmo_hit;

  assign raw = {btn_clear, btn_enter, btn_one, btn_zero};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // one-cycle press events; bit order: 0=zero 1=one 2=enter 3=clear
  assign ev       = deb & ~deb_q;
  assign digit_ev = ev[0] ^ ev[1];

`ifdef ENTRY_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES-1);

  logic [TO_W-1:0] idle_cnt;
  logic            active;

  assign active  = (state == ENTRY) || (state == FULL);
  assign tmo_hit = active && !(|ev) && (idle_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt      <= '0;
      entry_timeout <= 1'b0;
    end else begin
      entry_timeout <= tmo_hit;
      if (!active || (|ev) || tmo_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES < 2);
  assign tmo_hit        = 1'b0;
  assign entry_timeout  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      code        <= '0;
      digit_count <= '0;
      password    <= '0;
      open        <= 1'b0;
      entry_err   <= 1'b0;
    end else begin
      state       <= state_n;
      code        <= code_n;
      digit_count <= count_n;
      password    <= pw_n;
      open        <= open_n;
      entry_err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code;
    count_n = digit_count;
    pw_n    = password;
    open_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev[3]) begin
          state_n = IDLE;
        end else if (ev[2]) begin
          err_n = 1'b1;
        end else if (digit_ev) begin
          code_n  = {code[CODE_WIDTH-2:0], ev[1]};
          count_n = CNT_W'(1);
          state_n = ENTRY;
        end
      end
      ENTRY: begin
        if (ev[3] || ev[2] || tmo_hit) begin
          err_n   = ev[2] && !ev[3];
          code_n  = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (digit_ev) begin
          code_n  = {code[CODE_WIDTH-2:0], ev[1]};
          count_n = digit_count + CNT_W'(1);
          if (count_n == FULL_CNT) begin
            state_n = FULL;
          end
        end
      end
      FULL: begin
        if (ev[3] || (tmo_hit && !ev[2])) begin
          code_n  = '0;
          count_n = '0;
          state_n = IDLE;
        end else if (ev[2]) begin
          pw_n    = code;
          open_n  = 1'b1;
          state_n = SUBMIT;
        end
      end
      SUBMIT: begin
        code_n  = '0;
        count_n = '0;
        state_n = IDLE;
      end
      default: begin
        code_n  = '0;
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomised scoreboard bench for keypad_code_entry against a queue-based code model.
module tb_keypad_code_entry;

  localparam int CW = 4;
  localparam int DB = 4;
  localparam int TO = 64;
  localparam int NW = $clog2(CW+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_zero, btn_one, btn_enter, btn_clear;
  logic [CW-1:0] password;
  logic          open;
  logic [NW-1:0] digit_count;
  logic          entry_err;
  logic          entry_timeout;

  always #5 clk = ~clk;

  keypad_code_entry #(
    .CODE_WIDTH(CW),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_zero(btn_zero),
    .btn_one(btn_one),
    .btn_enter(btn_enter),
    .btn_clear(btn_clear),
    .password(password),
    .open(open),
    .digit_count(digit_count),
    .entry_err(entry_err),
    .entry_timeout(entry_timeout)
  );

  // kind: 0 = open with password, 1 = entry_err, 2 = entry_timeout
  typedef struct {
    int            kind;
    logic [CW-1:0] val;
  } exp_t;

  exp_t          exp_q[$];
  int            model[$];
  logic [CW-1:0] model_pw;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic pop(input int k, input logic [CW-1:0] v);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_pulse: got pulse kind %0d required none", k);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", k, e.kind);
      if (k == 0) check("password_on_open", v, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (open) pop(0, password);
      if (entry_err) pop(1, '0);
      if (entry_timeout) pop(2, '0);
    end
  end

  // Reference: code is a list of entered bits, at most CW long.
  task automatic model_event(input logic [3:0] m);
    int v;
    if (m[3]) begin
      model.delete();
    end else if (m[2]) begin
      if (model.size() == CW) begin
        v = 0;
        foreach (model[i]) v = v * 2 + model[i];
        model_pw = CW'(v);
        exp_q.push_back('{0, CW'(v)});
      end else begin
        exp_q.push_back('{1, '0});
      end
      model.delete();
    end else if (m[0] != m[1]) begin
      if (model.size() < CW) model.push_back(m[1] ? 1 : 0);
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {btn_clear, btn_enter, btn_one, btn_zero} = m;
  endtask

  task automatic press(input logic [3:0] m, input int blen);
    model_event(m);
    if (blen > 0) begin
      for (int i = 0; i < 10; i++) begin
        drive(i[0] ? 4'b0 : m);
        repeat (blen) @(negedge clk);
      end
    end
    drive(m);
    repeat (DB + 4 + $urandom_range(0, 3)) @(negedge clk);
    drive(4'b0);
    repeat (DB + 6) @(negedge clk);
    check("digit_count", digit_count, model.size());
    check("password_hold", password, model_pw);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_password"}, password, '0);
    check({tag, "_open"}, open, 0);
    check({tag, "_count"}, digit_count, 0);
    check({tag, "_err"}, entry_err, 0);
    check({tag, "_timeout"}, entry_timeout, 0);
  endtask

  localparam logic [3:0] K0 = 4'b0001;
  localparam logic [3:0] K1 = 4'b0010;
  localparam logic [3:0] KE = 4'b0100;
  localparam logic [3:0] KC = 4'b1000;

  initial begin
    logic [3:0] seq1 [5];
    logic [3:0] m;
    int r;
    model_pw = '0;
    reset = 1'b1;
    drive(4'b0);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    seq1 = '{K1, K0, K1, K0, KE};
    foreach (seq1[i]) press(seq1[i], 0);
    check("pw_1010", password, 4'b1010);

    press(K1, 2);
    press(KC, 0);

    press(K1, 0);
    press(K1, 0);
    press(K1, 0);
    press(KE, 0);
    check("pw_kept", password, 4'b1010);

    seq1 = '{K0, K1, K1, K1, K0};
    foreach (seq1[i]) press(seq1[i], 0);
    press(KE, 0);
    check("pw_0111", password, 4'b0111);

    press(K1, 0);
    press(K0, 0);
    press(K1, 0);
    press(KC, 0);

    repeat (4) press(K0, 0);
    press(KE | KC, 0);
    press(K0 | K1, 0);
    press(K1, 0);
    press(K0 | K1, 0);
    press(K0, 0);

    reset = 1'b1;
    @(negedge clk);
    model.delete();
    model_pw = '0;
    check_idle_outputs("midreset");
    // button held through reset: one event DB+2 cycles after release
    drive(K1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    check("held_before", digit_count, 0);
    @(negedge clk);
    check("held_after", digit_count, 1);
    model.push_back(1);
    drive(4'b0);
    repeat (DB + 6) @(negedge clk);

    press(K0, 0);
`ifdef ENTRY_TIMEOUT_EN
    exp_q.push_back('{2, '0});
    model.delete();
`endif
    repeat (TO + 16) @(negedge clk);
    check("timeout_count", digit_count, model.size());
    press(KC, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) m = K0;
      else if (r < 7) m = K1;
      else if (r == 7) m = KE;
      else if (r == 8) m = KC;
      else m = 4'($urandom_range(1, 15));
      press(m, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
